// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, default bit timing and receiver FSM states for the UART word receiver
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int WORD_W           = 32;
    localparam int WORD_BYTES       = 4;
    localparam int DEF_CLKS_PER_BIT = 130;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - rxd synchroniser and bit-level receive FSM; even parity when UART_RX_PARITY_EN is defined
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_done,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              sync1_q, sync1_d;
    logic              rxd_s_q, rxd_s_d;
    logic              rxd_prev_q, rxd_prev_d;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              tick;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    assign tick      = (cnt_q == '0);
    assign byte_data = shift_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Next-state logic: synchroniser shift, start-edge detect and mid-bit sampling
    always_comb begin
        sync1_d     = rxd;
        rxd_s_d     = sync1_q;
        rxd_prev_d  = rxd_s_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Only a high-to-low transition starts a frame; a line held low is ignored
                if (!rxd_s_q && rxd_prev_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rxd_s_q) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rxd_s_q;
                    cnt_d          = CNT_FULL;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d    = (rxd_s_q != ^shift_q);
                    parity_err_d = (rxd_s_q != ^shift_q);
                    cnt_d        = CNT_FULL;
                    state_d      = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    if (rxd_s_q) begin
`ifdef UART_RX_PARITY_EN
                        byte_done = !par_bad_q;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; synchroniser and edge register reset to the idle line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            rxd_s_q     <= rxd_s_d;
            rxd_prev_q  <= rxd_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - packs received UART bytes into 32-bit words behind a valid/ready holding register; UART_RX_PARITY_EN enables even parity
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              rxd,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    logic [BYTE_W-1:0]        byte_data;
    logic                     byte_done;
    logic [1:0]               lane_q, lane_d;
    logic [WORD_W-BYTE_W-1:0] part_q, part_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (PCLK),
        .rst       (PRESET),
        .rxd       (rxd),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign overrun    = overrun_q;

    // Lane packing and holding register; a completing word may replace one consumed on the same edge
    always_comb begin
        lane_d    = lane_q;
        part_d    = part_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
        if (byte_done) begin
            if (lane_q == LAST_LANE) begin
                lane_d = 2'd0;
                if (!valid_q || word_ready) begin
                    word_d  = {byte_data, part_q};
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                part_d[{lane_q, 3'b000} +: BYTE_W] = byte_data;
                lane_d = lane_q + 2'd1;
            end
        end
    end

    // Word-side registers; reset discards any partial word
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            lane_q    <= 2'd0;
            part_q    <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            part_q    <= part_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - scoreboard bench for uart_rx_word; frames carry a parity bit when UART_RX_PARITY_EN is defined
module tb_uart_rx_word;

    localparam int N = 130;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        rxd = 1'b1;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;

    uart_rx_word #(.CLKS_PER_BIT(N), .WORD_BYTES(4)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .rxd       (rxd),
        .word_ready(word_ready),
        .word_data (word_data),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int obs_frame = 0, obs_par = 0, obs_over = 0;
    int exp_frame = 0, exp_par = 0, exp_over = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mbytes[$];
    bit          pending = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts flag pulses and checks every transferred word against the scoreboard
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (frame_err)  obs_frame++;
            if (parity_err) obs_par++;
            if (overrun)    obs_over++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got 0x%08h expected no word", word_data);
                end else begin
                    check("sb_word", word_data, exp_q.pop_front());
                end
            end
        end
    end

    // Sends one frame; called and returns just after a rising edge
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit rdy_end);
        logic bits [0:10];
        logic [31:0] w;
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[j+1] = d[j];
        bits[9]  = (^d) ^ !par_ok;
        bits[STOP_IDX] = stop_ok;
        for (int j = 0; j <= STOP_IDX; j++) begin
            rxd = bits[j];
            if (j == STOP_IDX && rdy_end) begin
                repeat (2 + N/2) @(posedge PCLK);
                #1 word_ready = 1'b1;
                @(negedge PCLK);
                check("valid_before_completion", {31'd0, word_valid}, 32'd1);
                @(posedge PCLK);
                #1 word_ready = 1'b0;
                repeat (N - 3 - N/2) @(posedge PCLK);
                #1;
            end else begin
                repeat (N) @(posedge PCLK);
                #1;
            end
        end
        rxd = 1'b1;
        repeat (20) @(posedge PCLK);
        #1;
        if (!stop_ok) exp_frame++;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) exp_par++;
        if (stop_ok && par_ok) begin
`else
        if (stop_ok) begin
`endif
            mbytes.push_back(d);
            if (mbytes.size() == 4) begin
                w = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
                mbytes.delete();
                if (pending && !rdy_end) begin
                    exp_over++;
                end else begin
                    exp_q.push_back(w);
                    pending = 1;
                end
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_frame(w[8*b +: 8], 1'b1, 1'b1, 1'b0);
    endtask

    task automatic consume();
        word_ready = 1'b1;
        @(posedge PCLK);
        #1 word_ready = 1'b0;
        pending = 0;
        check("valid_cleared", {31'd0, word_valid}, 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_cnt"}, obs_frame, exp_frame);
        check({tag, "_parity_cnt"}, obs_par, exp_par);
        check({tag, "_overrun_cnt"}, obs_over, exp_over);
    endtask

    initial begin
        bit quiet_bad;
        logic [31:0] rw;

        // Reset values
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_word_data", word_data, 32'd0);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        PRESET = 1'b0;

        // Idle line: nothing happens
        quiet_bad = 0;
        repeat (2000) begin
            @(negedge PCLK);
            if (word_valid || frame_err || parity_err || overrun) quiet_bad = 1;
        end
        check("idle_quiet", {31'd0, quiet_bad}, 32'd0);
        @(posedge PCLK);
        #1;

        // Single word held until consumed
        send_word(32'hDEADBEEF);
        check("single_valid", {31'd0, word_valid}, 32'd1);
        check("single_data", word_data, 32'hDEADBEEF);
        repeat (50) @(posedge PCLK);
        #1;
        check("single_held", word_data, 32'hDEADBEEF);
        consume();

        // Framing error discards the byte without advancing the lane
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check_flags("ferr");
        send_word(32'h04030201);
        check("ferr_word", word_data, 32'h04030201);
        consume();

        // Glitch shorter than half a bit is ignored
        rxd = 1'b0;
        repeat (30) @(posedge PCLK);
        #1 rxd = 1'b1;
        repeat (100) @(posedge PCLK);
        #1;
        check_flags("glitch");
        check("glitch_no_word", {31'd0, word_valid}, 32'd0);
        rw = $urandom;
        send_word(rw);
        check("glitch_next_word", word_data, rw);
        consume();

        // Overrun with the consumer stalled
        send_word(32'h11223344);
        send_word(32'h55667788);
        check_flags("ovr");
        check("ovr_kept", word_data, 32'h11223344);
        check("ovr_valid", {31'd0, word_valid}, 32'd1);
        consume();

        // Consumer ready exactly on the completion edge
        send_word(32'h11223344);
        send_frame(8'h88, 1'b1, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        check_flags("swap");
        check("swap_data", word_data, 32'h55667788);
        check("swap_valid", {31'd0, word_valid}, 32'd1);
        consume();

        // Reset after two bytes discards the partial word
        send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b1, 1'b0);
        PRESET = 1'b1;
        #1;
        check("midrst_valid", {31'd0, word_valid}, 32'd0);
        mbytes.delete();
        exp_q.delete();
        pending = 0;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        send_word(32'hDDCCBBAA);
        check("midrst_word", word_data, 32'hDDCCBBAA);
        consume();

`ifdef UART_RX_PARITY_EN
        // Parity mismatch drops the byte
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        check_flags("par");
        send_word(32'h04030201);
        check("par_word", word_data, 32'h04030201);
        consume();
`endif

        // Randomized frames against the model
        for (int i = 0; i < 6; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 4) != 0), 1'b1, 1'b0);
            if (pending && $urandom_range(0, 1) == 1) consume();
        end
        if (pending) consume();

        check_flags("final");
        check("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
